// File: rtl/bdm_cmd_sequencer.sv
// bdm_cmd_sequencer: expands one host BDC command into ordered bdm byte strobes
// (write/delay/read/start/stop) and returns a single response per command.
module bdm_cmd_sequencer #(
  parameter logic [7:0] ACCESS_DELAY   = 8'd2,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        bdm_do_start_mcu,
  output logic        bdm_do_stop_mcu,
  output logic        bdm_do_read,
  output logic        bdm_do_write,
  output logic        bdm_do_delay,
  output logic [7:0]  bdm_wdata,
  input  logic [7:0]  bdm_rdata,
  input  logic        bdm_ready,
  input  logic        bdm_valid
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WMAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  typedef enum logic [2:0] {K_WR, K_DLY, K_RD, K_START, K_STOP} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [7:0] data;
    logic       last;
  } step_t;

  // Step table: what to issue for step idx of op, and whether it is the final step.
  function automatic step_t decode(input logic [2:0] op, input logic [2:0] idx,
                                   input logic [15:0] addr, input logic [7:0] wd);
    step_t s;
    s.kind = K_WR;
    s.data = 8'h00;
    s.last = 1'b0;
    case (op)
      3'd0: begin s.kind = K_START; s.last = 1'b1; end
      3'd1: begin s.kind = K_STOP;  s.last = 1'b1; end
      3'd2: case (idx)
        3'd0:    s.data = 8'hE0;
        3'd1:    s.data = addr[15:8];
        3'd2:    s.data = addr[7:0];
        3'd3:    begin s.kind = K_DLY; s.data = ACCESS_DELAY; end
        default: begin s.kind = K_RD;  s.last = 1'b1; end
      endcase
      3'd3: case (idx)
        3'd0:    s.data = 8'hC0;
        3'd1:    s.data = addr[15:8];
        3'd2:    s.data = addr[7:0];
        3'd3:    s.data = wd;
        default: begin s.kind = K_DLY; s.data = ACCESS_DELAY; s.last = 1'b1; end
      endcase
      3'd4: if (idx == 3'd0) s.data = 8'h90;
            else begin s.kind = K_DLY; s.data = ACCESS_DELAY; s.last = 1'b1; end
      3'd5: begin s.data = 8'h08; s.last = 1'b1; end
      3'd6: if (idx == 3'd0) s.data = 8'hE4;
            else begin s.kind = K_RD; s.last = 1'b1; end
      default: if (idx == 3'd0) s.data = 8'hC4;
               else begin s.data = wd; s.last = 1'b1; end
    endcase
    return s;
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d, idx_q, idx_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wd_q, wd_d, rd_q, rd_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [4:0]    strb_q, strb_d;   // {stop, start, read, delay, write}
  logic [7:0]    bwd_q, bwd_d;
  logic          rspv_q, rspv_d, rspto_q, rspto_d;
  logic [7:0]    rspd_q, rspd_d;

  step_t cur, nxt;
  logic  issue;

  // Next-state, step sequencing and registered strobe/response computation.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    wcnt_d  = wcnt_q;
    strb_d  = 5'b0;
    bwd_d   = 8'h00;
    rspv_d  = 1'b0;
    rspto_d = 1'b0;
    rspd_d  = 8'h00;
    issue   = 1'b0;
    cur     = decode(op_q, idx_q, addr_q, wd_q);
    nxt     = decode(op_q, idx_q + 3'd1, addr_q, wd_q);
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        addr_d  = cmd_addr;
        wd_d    = cmd_wdata;
        idx_d   = 3'd0;
        rd_d    = 8'h00;
        state_d = ISSUE;
        issue   = 1'b1;
        nxt     = decode(cmd_op, 3'd0, cmd_addr, cmd_wdata);
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bdm_valid) rd_d = bdm_rdata;
        if (bdm_ready) begin
          if (cur.last) begin
            state_d = IDLE;
            rspv_d  = 1'b1;
            // Read byte arrives with ready on the last step, so take it straight from bdm.
            if (op_q == 3'd2 || op_q == 3'd6) rspd_d = bdm_valid ? bdm_rdata : rd_q;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ISSUE;
            issue   = 1'b1;
          end
        end else if (wcnt_q == WMAX) begin
          rspv_d  = 1'b1;
          rspto_d = 1'b1;
          state_d = DRAIN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: if (bdm_ready) state_d = IDLE;
    endcase
    if (issue) begin
      case (nxt.kind)
        K_WR:    begin strb_d[0] = 1'b1; bwd_d = nxt.data; end
        K_DLY:   begin strb_d[1] = 1'b1; bwd_d = nxt.data; end
        K_RD:    strb_d[2] = 1'b1;
        K_START: strb_d[3] = 1'b1;
        default: strb_d[4] = 1'b1;
      endcase
    end
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      wcnt_q  <= '0;
      strb_q  <= '0;
      bwd_q   <= '0;
      rspv_q  <= 1'b0;
      rspto_q <= 1'b0;
      rspd_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      wcnt_q  <= wcnt_d;
      strb_q  <= strb_d;
      bwd_q   <= bwd_d;
      rspv_q  <= rspv_d;
      rspto_q <= rspto_d;
      rspd_q  <= rspd_d;
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign bdm_do_write     = strb_q[0];
  assign bdm_do_delay     = strb_q[1];
  assign bdm_do_read      = strb_q[2];
  assign bdm_do_start_mcu = strb_q[3];
  assign bdm_do_stop_mcu  = strb_q[4];
  assign bdm_wdata        = bwd_q;
  assign rsp_valid        = rspv_q;
  assign rsp_data         = rspd_q;
  assign rsp_timeout      = rspto_q;

endmodule

// File: doc/bdm_cmd_sequencer.md
# bdm_cmd_sequencer

Host-facing command sequencer for the `bdm` block. It accepts one high-level BDC command at a time over a valid/ready port. It expands each command into the ordered byte-level strobes `bdm` accepts: write opcode, write address bytes, write data, ACK delay, read. It returns one response per command with the read byte and a timeout flag. It sits between the host/UART command decoder and `bdm`, and it is the only driver of the `bdm` `do_*` and `data_in` inputs.

## Interface
- ACCESS_DELAY, 8'd2, value driven on `bdm_wdata` with `bdm_do_delay`
- TIMEOUT_CYCLES, 65535, max cycles spent waiting in one step before abort (≥2)
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 POWER_UP, 1 POWER_DOWN, 2 READ_BYTE, 3 WRITE_BYTE, 4 BACKGROUND, 5 GO, 6 READ_STATUS, 7 WRITE_CONTROL
- cmd_addr  in  16  target address (ops 2, 3)
- cmd_wdata  in  8  write data (ops 3, 7)
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  8  read byte (ops 2, 6), else 0
- rsp_timeout  out  1  command aborted by timeout
- busy  out  1  command in progress (state ≠ IDLE)
- bdm_do_start_mcu, bdm_do_stop_mcu, bdm_do_read, bdm_do_write, bdm_do_delay  out  1 each  one-cycle strobes to `bdm`
- bdm_wdata  out  8  to `bdm` data_in
- bdm_rdata  in  8  from `bdm` data_out
- bdm_ready  in  1  `bdm` idle; combinationally low while any `do_*` is high
- bdm_valid  in  1  `bdm` read data valid

## Operation
- Step sequences: W(x) = write byte x, D = delay, R = read, S = start, P = stop.
  - POWER_UP: S
  - POWER_DOWN: P
  - READ_BYTE: W(E0) W(addr[15:8]) W(addr[7:0]) D R
  - WRITE_BYTE: W(C0) W(addr[15:8]) W(addr[7:0]) W(wdata) D
  - BACKGROUND: W(90) D
  - GO: W(08)
  - READ_STATUS: W(E4) R
  - WRITE_CONTROL: W(C4) W(wdata)
- Step index: 3-bit counter, at most 5 steps per command.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch op/addr/wdata, clear step index and read register, go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert the current step's strobe and drive `bdm_wdata` (byte for W, ACCESS_DELAY for D, 0 otherwise).
  - Clear the wait counter. Go to WAIT.
- WAIT:
  - If bdm_valid, latch bdm_rdata into the read register.
  - If bdm_ready: if this is the last step, go to IDLE with the response; else increment the step index and go to ISSUE.
  - Else, if the wait counter = TIMEOUT_CYCLES−1: rsp_valid = 1, rsp_timeout = 1, rsp_data = 0, go to DRAIN.
  - Else increment the wait counter.
- DRAIN:
  - Hold cmd_ready = 0 and assert no strobes.
  - Go to IDLE on the first cycle bdm_ready = 1.
- Strobes are registered, mutually exclusive, and never high outside ISSUE.
- Only one command is outstanding. cmd_* inputs are ignored while cmd_ready = 0.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, cmd_ready 1, busy 0, rsp_valid 0, rsp_data 0, rsp_timeout 0, all bdm_do_* 0, bdm_wdata 0. Reset takes effect immediately and asynchronously.
- Reset mid-command: drops all strobes, abandons the command, and emits no response.
- Accept edge at cycle T: first strobe at T+1. WAIT starts at T+2. A step is complete on the first WAIT cycle with bdm_ready = 1; the next strobe follows one cycle later.
- POWER_DOWN: `bdm` is ready again the cycle after the strobe, so rsp_valid is at T+3.
- Response:
  - rsp_valid is registered and asserted the cycle after the final completing WAIT cycle.
  - rsp_data and rsp_timeout are valid only with rsp_valid.
  - rsp_timeout = 0 on normal completion.
  - cmd_ready returns in the same cycle as rsp_valid, so back-to-back commands are allowed.
- bdm_valid and bdm_ready rise together at read completion. The byte is captured in that same cycle.
- Wait counter width is $clog2(TIMEOUT_CYCLES). Timeout fires exactly TIMEOUT_CYCLES WAIT cycles after ISSUE if bdm_ready stays low. The counter never wraps.

## Test plan
- Reset, then POWER_UP with the `bdm` model ready after 10 cycles → exactly one bdm_do_start_mcu pulse at T+1; rsp_valid with rsp_data 00, rsp_timeout 0; cmd_ready low until response.
- READ_BYTE addr 0x1234, model returns 0xA5, ACCESS_DELAY 2 → strobes in order: write E0, write 12, write 34, delay with wdata 02, read. rsp_data = A5.
- WRITE_BYTE addr 0x0080 data 0x3C, then GO offered back-to-back on the response cycle → bytes C0 00 80 3C then a delay strobe, rsp_valid; GO accepted in the rsp_valid cycle; write 08 follows; second rsp_valid.
- POWER_DOWN → single bdm_do_stop_mcu pulse, rsp_valid at T+3.
- TIMEOUT_CYCLES = 16, model holds bdm_ready low after W(90) of BACKGROUND → rsp_valid with rsp_timeout 1 after 16 WAIT cycles. No further strobes. cmd_ready stays 0 until the model raises ready, then returns to 1.
- Assert rst low during the W(addr lo) step of READ_BYTE → all outputs reset immediately; no rsp_valid; a new READ_STATUS after release completes normally.
